// File: rtl/exec_store_arbiter_if.sv
// rtl/exec_store_arbiter_if.sv - requester/store-stage bundle for the execute-to-store slot arbiter
interface exec_store_arbiter_if #(
  parameter int NUM_REQ  = 3,
  parameter int PACKET_W = 256
);
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*PACKET_W-1:0] req_data;
  logic [NUM_REQ-1:0]          req_accept;
  logic                        out_busy;
  logic [PACKET_W-1:0]         out_data;
  logic                        out_recv;
  logic                        pc_done;
  logic                        barrier_active;
  logic                        protocol_err;

  modport master (
    output req_valid, req_data, out_recv, pc_done,
    input  req_accept, out_busy, out_data, barrier_active, protocol_err
  );

  modport slave (
    input  req_valid, req_data, out_recv, pc_done,
    output req_accept, out_busy, out_data, barrier_active, protocol_err
  );
endinterface

// File: rtl/exec_store_arbiter.sv
// rtl/exec_store_arbiter.sv - round-robin execute-to-store slot arbiter with PC-write barrier
module exec_store_arbiter #(
  parameter int NUM_REQ         = 3,
  parameter int PACKET_W        = 256,
  parameter int STORE_TO_PC_BIT = 0,
  parameter int PTR_W           = 2
) (
  input logic                 clk,
  input logic                 reset_n,
  exec_store_arbiter_if.slave bus
);

  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    rr_next;
  logic [PTR_W-1:0]    winner;
  logic [NUM_REQ-1:0]  accept;
  logic [PACKET_W-1:0] win_data;
  logic [PACKET_W-1:0] out_data;
  logic                out_busy;
  logic                barrier_active;
  logic                protocol_err;
  logic                slot_free;
  logic                grant_en;
  logic                grant;
  logic                recv_err;
  logic                pc_err;
  int                  idx;

  // Gating with reset_n keeps req_accept low while reset is held.
  assign slot_free = !out_busy || bus.out_recv;
  assign grant_en  = reset_n && slot_free && !barrier_active && (bus.req_valid != '0);
  assign recv_err  = bus.out_recv && !out_busy;
  assign pc_err    = bus.pc_done && !barrier_active;

  always_comb begin
    accept   = '0;
    winner   = '0;
    win_data = '0;
    grant    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (grant_en && !grant && bus.req_valid[idx]) begin
        grant       = 1'b1;
        accept[idx] = 1'b1;
        winner      = PTR_W'(idx);
        win_data    = bus.req_data[idx*PACKET_W +: PACKET_W];
      end
    end
  end

  assign rr_next = (int'(winner) == NUM_REQ - 1) ? '0 : winner + PTR_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_busy       <= 1'b0;
      out_data       <= '0;
      rr_ptr         <= '0;
      barrier_active <= 1'b0;
      protocol_err   <= 1'b0;
    end else begin
      if (grant) begin
        out_data <= win_data;
        out_busy <= 1'b1;
        rr_ptr   <= rr_next;
        if (win_data[STORE_TO_PC_BIT]) begin
          barrier_active <= 1'b1;
        end
      end else if (bus.out_recv) begin
        out_busy <= 1'b0;
      end
      // The barrier blocks grants, so a clear can never race a new arm.
      if (bus.pc_done && barrier_active) begin
        barrier_active <= 1'b0;
      end
      if (recv_err || pc_err) begin
        protocol_err <= 1'b1;
      end
    end
  end

  assign bus.req_accept     = accept;
  assign bus.out_busy       = out_busy;
  assign bus.out_data       = out_data;
  assign bus.barrier_active = barrier_active;
  assign bus.protocol_err   = protocol_err;

endmodule

// File: tb/tb_exec_store_arbiter.sv
// tb/tb_exec_store_arbiter.sv - self-checking bench for exec_store_arbiter
module tb_exec_store_arbiter;
  localparam int N = 3;
  localparam int W = 256;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  exec_store_arbiter_if #(.NUM_REQ(N), .PACKET_W(W)) bus();

  exec_store_arbiter #(.NUM_REQ(N), .PACKET_W(W), .STORE_TO_PC_BIT(0), .PTR_W(2)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave)
  );

  int passed = 0;
  int total  = 0;

  logic [W-1:0] pkt [N];
  logic         m_busy, m_barrier, m_err;
  logic [W-1:0] m_data;
  int           m_ptr;

  function automatic logic [W-1:0] rand_pkt(bit pc);
    logic [W-1:0] p;
    for (int i = 0; i < W/32; i++) p[i*32 +: 32] = $urandom;
    p[0] = pc;
    return p;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_data = '0; m_ptr = 0; m_barrier = 1'b0; m_err = 1'b0;
  endtask

  task automatic apply(logic [N-1:0] v, bit recv, bit pcd);
    bus.req_valid = v;
    bus.out_recv  = recv;
    bus.pc_done   = pcd;
    for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = pkt[i];
    #1;
  endtask

  // Winner is the valid requester at the smallest cyclic distance from the pointer.
  function automatic logic [N-1:0] exp_accept();
    logic [N-1:0] a;
    int best;
    int bestd;
    a = '0;
    if (!reset_n || (m_busy && !bus.out_recv) || m_barrier) return a;
    best = -1;
    bestd = N;
    for (int i = 0; i < N; i++)
      if (bus.req_valid[i] && ((i - m_ptr + N) % N) < bestd) begin
        bestd = (i - m_ptr + N) % N;
        best = i;
      end
    if (best >= 0) a[best] = 1'b1;
    return a;
  endfunction

  task automatic advance();
    logic [N-1:0] a;
    logic [W-1:0] nd;
    logic         nb, nbar, nerr;
    int           w, np;
    a = exp_accept();
    w = -1;
    for (int i = 0; i < N; i++) if (a[i]) w = i;
    nb = m_busy; nd = m_data; np = m_ptr; nbar = m_barrier;
    if (w >= 0) begin
      nd = pkt[w]; nb = 1'b1; np = (w + 1) % N;
      if (pkt[w][0]) nbar = 1'b1;
    end else if (bus.out_recv) begin
      nb = 1'b0;
    end
    if (bus.pc_done && m_barrier) nbar = 1'b0;
    nerr = m_err | (bus.out_recv & ~m_busy) | (bus.pc_done & ~m_barrier);
    @(posedge clk);
    m_busy = nb; m_data = nd; m_ptr = np; m_barrier = nbar; m_err = nerr;
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    for (int i = 0; i < N; i++) pkt[i] = rand_pkt(0);
    apply('0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    apply('0, 0, 0);
    total++; if (bus.out_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.out_busy); else passed++;
    total++; if (bus.out_data !== '0) $display("FAIL rst_data: got %h want 0", bus.out_data); else passed++;
    total++; if (bus.barrier_active !== 1'b0) $display("FAIL rst_barrier: got %b want 0", bus.barrier_active); else passed++;
    total++; if (bus.protocol_err !== 1'b0) $display("FAIL rst_err: got %b want 0", bus.protocol_err); else passed++;
    pkt[2] = rand_pkt(1);
    apply(3'b100, 0, 0);
    total++; if (bus.req_accept !== 3'b100) $display("FAIL rst_pre_accept: got %b want 100", bus.req_accept); else passed++;
    advance();
    total++; if ({bus.out_busy, bus.barrier_active} !== 2'b11) $display("FAIL rst_pre_state: got %b want 11", {bus.out_busy, bus.barrier_active}); else passed++;
    reset_n = 1'b0;
    apply(3'b111, 1, 0);
    total++; if (bus.req_accept !== 3'b000) $display("FAIL rst_low_accept: got %b want 000", bus.req_accept); else passed++;
    total++; if ({bus.out_busy, bus.barrier_active, bus.protocol_err} !== 3'b000) $display("FAIL rst_low_state: got %b want 000", {bus.out_busy, bus.barrier_active, bus.protocol_err}); else passed++;
    @(posedge clk);
    #1;
    total++; if (bus.req_accept !== 3'b000) $display("FAIL rst_low_accept2: got %b want 000", bus.req_accept); else passed++;
    reset_n = 1'b1;
    model_reset();
    pkt[2] = rand_pkt(0);
    apply(3'b111, 0, 0);
    total++; if (bus.req_accept !== 3'b001) $display("FAIL rst_first_grant: got %b want 001", bus.req_accept); else passed++;
    advance();
    total++; if (bus.out_data !== pkt[0]) $display("FAIL rst_first_data: got %h want %h", bus.out_data, pkt[0]); else passed++;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] want;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      want = 3'b001 << (i % 3);
      apply(3'b111, i != 0, 0);
      total++; if (bus.req_accept !== want) $display("FAIL rr_accept%0d: got %b want %b", i, bus.req_accept, want); else passed++;
      advance();
      total++; if (bus.out_busy !== 1'b1 || bus.out_data !== m_data) $display("FAIL rr_out%0d: got %b/%h want 1/%h", i, bus.out_busy, bus.out_data, m_data); else passed++;
      pkt[i % 3] = rand_pkt(0);
    end
  endtask

  task automatic test_back_pressure();
    logic [W-1:0] d0;
    do_reset();
    apply(3'b010, 0, 0);
    total++; if (bus.req_accept !== 3'b010) $display("FAIL bp_first: got %b want 010", bus.req_accept); else passed++;
    advance();
    d0 = pkt[1];
    total++; if (bus.out_busy !== 1'b1 || bus.out_data !== d0) $display("FAIL bp_load: got %b/%h want 1/%h", bus.out_busy, bus.out_data, d0); else passed++;
    pkt[1] = rand_pkt(0);
    for (int i = 0; i < 3; i++) begin
      apply(3'b010, 0, 0);
      total++; if (bus.req_accept !== 3'b000) $display("FAIL bp_stall%0d: got %b want 000", i, bus.req_accept); else passed++;
      advance();
      total++; if (bus.out_data !== d0 || bus.out_busy !== 1'b1) $display("FAIL bp_hold%0d: got %b/%h want 1/%h", i, bus.out_busy, bus.out_data, d0); else passed++;
    end
    apply(3'b010, 1, 0);
    total++; if (bus.req_accept !== 3'b010) $display("FAIL bp_regrant: got %b want 010", bus.req_accept); else passed++;
    advance();
    total++; if (bus.out_busy !== 1'b1 || bus.out_data !== pkt[1]) $display("FAIL bp_reload: got %b/%h want 1/%h", bus.out_busy, bus.out_data, pkt[1]); else passed++;
  endtask

  task automatic test_barrier();
    do_reset();
    pkt[2] = rand_pkt(1);
    for (int i = 0; i < 3; i++) begin
      apply(3'b111, i != 0, 0);
      total++; if (bus.req_accept !== (3'b001 << i)) $display("FAIL bar_fill%0d: got %b want %b", i, bus.req_accept, 3'b001 << i); else passed++;
      advance();
      if (i < 2) pkt[i] = rand_pkt(0);
    end
    total++; if (bus.barrier_active !== 1'b1) $display("FAIL bar_armed: got %b want 1", bus.barrier_active); else passed++;
    for (int i = 0; i < 5; i++) begin
      apply(3'b011, m_busy, 0);
      total++; if (bus.req_accept !== 3'b000) $display("FAIL bar_block%0d: got %b want 000", i, bus.req_accept); else passed++;
      advance();
      total++; if (bus.barrier_active !== 1'b1) $display("FAIL bar_hold%0d: got %b want 1", i, bus.barrier_active); else passed++;
    end
    apply(3'b011, 0, 1);
    total++; if (bus.req_accept !== 3'b000) $display("FAIL bar_pcdone_accept: got %b want 000", bus.req_accept); else passed++;
    advance();
    total++; if ({bus.barrier_active, bus.protocol_err} !== 2'b00) $display("FAIL bar_clear: got %b want 00", {bus.barrier_active, bus.protocol_err}); else passed++;
    apply(3'b011, 0, 0);
    total++; if (bus.req_accept !== 3'b001) $display("FAIL bar_resume: got %b want 001", bus.req_accept); else passed++;
    advance();
    total++; if (bus.out_data !== pkt[0] || bus.out_busy !== 1'b1) $display("FAIL bar_resume_data: got %b/%h want 1/%h", bus.out_busy, bus.out_data, pkt[0]); else passed++;
  endtask

  task automatic test_protocol_err();
    do_reset();
    apply('0, 1, 0);
    advance();
    total++; if (bus.protocol_err !== 1'b1) $display("FAIL perr_recv: got %b want 1", bus.protocol_err); else passed++;
    total++; if ({bus.out_busy, bus.barrier_active} !== 2'b00 || bus.out_data !== '0) $display("FAIL perr_recv_state: got %b/%h want 00/0", {bus.out_busy, bus.barrier_active}, bus.out_data); else passed++;
    do_reset();
    apply('0, 0, 1);
    advance();
    total++; if (bus.protocol_err !== 1'b1) $display("FAIL perr_pcdone: got %b want 1", bus.protocol_err); else passed++;
    total++; if (bus.barrier_active !== 1'b0) $display("FAIL perr_pcdone_bar: got %b want 0", bus.barrier_active); else passed++;
    apply('0, 0, 0);
    advance();
    total++; if (bus.protocol_err !== 1'b1) $display("FAIL perr_sticky: got %b want 1", bus.protocol_err); else passed++;
  endtask

  task automatic test_pointer_skip();
    do_reset();
    apply(3'b001, 0, 0);
    total++; if (bus.req_accept !== 3'b001) $display("FAIL skip_setup: got %b want 001", bus.req_accept); else passed++;
    advance();
    apply(3'b101, 1, 0);
    total++; if (bus.req_accept !== 3'b100) $display("FAIL skip_to2: got %b want 100", bus.req_accept); else passed++;
    advance();
    total++; if (bus.out_data !== pkt[2]) $display("FAIL skip_data2: got %h want %h", bus.out_data, pkt[2]); else passed++;
    apply(3'b101, 1, 0);
    total++; if (bus.req_accept !== 3'b001) $display("FAIL skip_wrap0: got %b want 001", bus.req_accept); else passed++;
    advance();
    total++; if (bus.out_data !== pkt[0]) $display("FAIL skip_data0: got %h want %h", bus.out_data, pkt[0]); else passed++;
  endtask

  task automatic test_random();
    logic [N-1:0] v;
    logic [N-1:0] ea;
    bit           recv, pcd;
    do_reset();
    v = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i]) begin
          if ($urandom % 3 == 0) begin
            pkt[i] = rand_pkt($urandom % 10 == 0);
            v[i] = 1'b1;
          end
        end else if ($urandom % 16 == 0) begin
          v[i] = 1'b0;
        end
      end
      recv = m_busy ? ($urandom % 4 != 0) : ($urandom % 50 == 0);
      pcd  = m_barrier ? ($urandom % 4 == 0) : ($urandom % 100 == 0);
      apply(v, recv, pcd);
      ea = exp_accept();
      total++; if (bus.req_accept !== ea) $display("FAIL rnd_accept c%0d: got %b want %b", c, bus.req_accept, ea); else passed++;
      advance();
      for (int i = 0; i < N; i++)
        if (ea[i]) begin
          v[i] = 1'($urandom % 2);
          pkt[i] = rand_pkt($urandom % 10 == 0);
        end
      total++; if ({bus.out_busy, bus.barrier_active, bus.protocol_err} !== {m_busy, m_barrier, m_err})
        $display("FAIL rnd_state c%0d: got %b want %b", c, {bus.out_busy, bus.barrier_active, bus.protocol_err}, {m_busy, m_barrier, m_err});
      else passed++;
      total++; if (bus.out_data !== m_data) $display("FAIL rnd_data c%0d: got %h want %h", c, bus.out_data, m_data); else passed++;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    test_reset();
    test_round_robin();
    test_back_pressure();
    test_barrier();
    test_protocol_err();
    test_pointer_skip();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/exec_store_arbiter.md
Name: exec_store_arbiter

Overview:
- Shares the single execute-to-store packet slot between NUM_REQ execute-side producers (ALU, branch unit, address-gen unit).
- Selects one requester per cycle by round-robin and holds the chosen packet in a busy/recv-style output register for the store stage.
- Enforces a PC-write barrier: once a packet that stores to the PC has been issued, no further grants are made until the store stage confirms the PC update.

Parameters:
NUM_REQ, 3, number of requester ports (2..8)
PACKET_W, 256, width of one flattened execute-stage packet
STORE_TO_PC_BIT, 0, bit index in the packet of the store-to-PC flag
PTR_W, 2, round-robin pointer width; must satisfy 2**PTR_W >= NUM_REQ

Ports:
clk  in  1  clock; all state updates on the rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  requester i holds a packet
req_data  in  NUM_REQ*PACKET_W  packet of requester i, in slice [i*PACKET_W +: PACKET_W]
req_accept  out  NUM_REQ  one-hot, combinational; requester i's packet is taken at this edge
out_busy  out  1  output slot holds an unconsumed packet
out_data  out  PACKET_W  packet in the output slot
out_recv  in  1  store stage consumes out_data this cycle
pc_done  in  1  single-cycle pulse: store stage has committed the PC write
barrier_active  out  1  PC-write barrier is armed
protocol_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (asynchronous, reset_n=0): out_busy=0, out_data=0, rr_ptr=0, barrier_active=0, protocol_err=0. req_accept is 0 while reset is asserted. An in-flight packet is discarded.
- slot_free = !out_busy || out_recv. A packet can be consumed and a new one loaded in the same cycle, giving full throughput of one packet per cycle.
- grant_en = slot_free && !barrier_active && (req_valid != 0).
- Arbitration:
  - Search starts at rr_ptr and proceeds upward with wrap modulo NUM_REQ.
  - The first i with req_valid[i]=1 wins; req_accept[i]=1 combinationally and all other bits are 0.
  - With grant_en=0, req_accept=0.
- On the edge where a grant occurs:
  - out_data <= winning packet; out_busy <= 1.
  - rr_ptr <= (winner+1) mod NUM_REQ.
  - If the packet's STORE_TO_PC_BIT is 1: barrier_active <= 1.
- With out_recv=1 and no grant: out_busy <= 0. out_data holds its last value.
- With no grant: rr_ptr is unchanged. An idle requester set does not move the pointer.
- Latency: packet appears at out_data/out_busy one cycle after its accept. Requesters must hold req_data stable while req_valid=1 and not accepted.
- Barrier:
  - While barrier_active=1, no grant is made, even if the slot is free.
  - pc_done=1 clears barrier_active at the edge, and granting resumes in the following cycle.
  - pc_done has no effect on the output slot itself.
- Protocol errors (protocol_err is set sticky; only reset clears it):
  - out_recv=1 while out_busy=0. The recv is ignored.
  - pc_done=1 while barrier_active=0. The pulse is ignored.
- A requester dropping req_valid before accept is legal and causes no error.
- NUM_REQ=1 degenerates to a single-entry pass register with the barrier still active.

Test Plan:
- Reset mid-operation: out_busy=1 and barrier_active=1, pulse reset_n low for 1 cycle -> out_busy=0, barrier_active=0, protocol_err=0, req_accept=0 while low; the first grant after release goes to requester 0.
- Round-robin fairness: req_valid=3'b111 held, out_recv=1 every cycle -> accept sequence 001,010,100,001; out_busy stays 1 continuously; one packet per cycle.
- Back-pressure: out_recv=0 with req_valid=3'b010 -> one accept only, then req_accept=0 and out_data stable; assert out_recv=1 -> same-cycle re-grant of requester 1's next packet, out_busy stays 1.
- Barrier: requester 2 sends a packet with bit0=1, req_valid=3'b011 held -> barrier_active=1 one cycle later, no accepts during 5 cycles even with out_recv=1; pc_done pulse -> barrier_active=0, requester 0 is accepted next cycle.
- Protocol errors: out_recv=1 with out_busy=0 -> protocol_err=1 next cycle and the state is otherwise unchanged; pc_done with barrier_active=0 on a fresh reset -> protocol_err=1.
- Pointer skip: rr_ptr=1, req_valid=3'b101 -> requester 2 is accepted and rr_ptr becomes 0; next cycle with req_valid=3'b101 -> requester 0 is accepted.
